seq_gen_4bit: RTL

- Serial pattern transmitter: the source side of the serial sequence-detector path.
- On a start request it captures a 4-bit pattern and a repeat count. It then shifts the pattern out one bit per clock on a single serial line, with a qualifying valid strobe.
- Optional idle gap between repetitions; one-cycle completion pulse at the end.
- Used to drive the 4-bit sequence detectors on `in` for loopback test and for in-system pattern injection.

---
 rtl/seq_gen_4bit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_gen_4bit.sv
// seq_gen_4bit
// Serial pattern transmitter. On an accepted start it captures a 4-bit
// pattern and a repeat count, then shifts the pattern out one bit per clock
// with a qualifying valid strobe. An optional idle gap separates repetitions,
// and a one-cycle done pulse follows the last bit.
//
// Parameters:
//   GAP       : idle cycles between consecutive repetitions (0..15)
//   LSB_FIRST : 0 = pattern[3] sent first, 1 = pattern[0] sent first
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-low reset
//   start     : transfer request, accepted only in IDLE
//   pattern   : 4-bit pattern, captured on the accepting edge
//   reps      : repetition count minus one, captured on the accepting edge
//   out       : serial data bit, 0 whenever out_valid is 0
//   out_valid : out carries a pattern bit this cycle
//   busy      : transfer in progress (SHIFT or GAP)
//   done      : one-cycle pulse after the last bit
//
// Handshake: start is a level sampled at each rising edge; it is acted on only
// when the FSM is IDLE, otherwise it is dropped (never queued). There is no
// back-pressure on the serial side: every cycle with out_valid=1 carries one
// bit that the consumer must take.
module seq_gen_4bit #(
  parameter int unsigned GAP       = 0,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic [3:0] reps,
  output logic       out,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Terminal value of the gap counter; the counter runs 0..GAP-1.
  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] rep_q, rep_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;

  logic [1:0] bit_sel;
  logic       out_d;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          rep_d   = reps;
          idx_d   = 2'd0;
          gap_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (rep_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            rep_d = rep_q - 4'd1;
            if (GAP != 0) begin
              gap_d   = 4'd0;
              state_d = S_GAP;
            end
            // GAP == 0: stay in SHIFT at index 0, no bubble.
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          idx_d   = 2'd0;
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DONE: begin
        // start is deliberately ignored here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state presents, so they
  // line up with the state during the following cycle.
  always_comb begin
    bit_sel = LSB_FIRST ? idx_d : ~idx_d;
    out_d   = (state_d == S_SHIFT) && pat_d[bit_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= 4'd0;
      rep_q     <= 4'd0;
      idx_q     <= 2'd0;
      gap_q     <= 4'd0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      out       <= out_d;
      out_valid <= (state_d == S_SHIFT);
      busy      <= (state_d == S_SHIFT) || (state_d == S_GAP);
      done      <= (state_d == S_DONE);
    end
  end

endmodule
